ram_read_arbiter: RTL and testbench

- Shares one synchronous-read image RAM (8-bit data, 19-bit address, one-cycle read latency) between several pixel fetchers, e.g. background, player 1 sprite and player 2 sprite.
- Accepts at most one read per clock using a valid/ready handshake and round-robin arbitration.
- Drives the RAM address port directly.
- Returns each read's data to the requester that issued it, tagged by a one-hot response valid.
- Sits between the per-layer draw logic and the RAM instance inside the frame compositor.

---
 rtl/ram_read_arbiter_if.sv | 50 +++++
 rtl/ram_read_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ram_read_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_read_arbiter_if
// Bundles the requester handshake, the RAM read port and the tagged response
// path of the shared image-RAM read arbiter.
//
//   req_valid  NUM_REQ         per-requester read request
//   req_addr   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready  NUM_REQ         one-hot grant (accept = valid & ready at a rising edge)
//   ram_addr   ADDR_W          address to the RAM read port
//   ram_data   DATA_W          registered read data from the RAM
//   rsp_valid  NUM_REQ         one-hot response tag, one cycle per accepted read
//   rsp_data   DATA_W          read data returned to the tagged requester
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the RAM instance)
// -----------------------------------------------------------------------------
interface ram_read_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport slave (
    input  req_valid,
    input  req_addr,
    input  ram_data,
    output req_ready,
    output ram_addr,
    output rsp_valid,
    output rsp_data
  );

  modport master (
    output req_valid,
    output req_addr,
    output ram_data,
    input  req_ready,
    input  ram_addr,
    input  rsp_valid,
    input  rsp_data
  );
endinterface

// File: rtl/ram_read_arbiter.sv
// -----------------------------------------------------------------------------
// ram_read_arbiter
// Shares one synchronous-read image RAM between NUM_REQ pixel fetchers.
// At most one read is accepted per clock; the winner is chosen round-robin
// starting at rr_ptr. The granted address goes straight to the RAM port, and a
// RAM_LAT-deep tag pipeline follows each read so that the returned data can be
// flagged with a one-hot rsp_valid for the requester that issued it.
//
// Ports:
//   Clk    - system clock, all state updates on the rising edge
//   Reset  - asynchronous, active-low reset
//   bus    - ram_read_arbiter_if.slave (request, RAM and response signals)
//
// Optional build macro:
//   ARB_BG_PRIORITY_EN - requester 0 (background stream) always wins when it
//                        is valid; requesters 1..NUM_REQ-1 share the
//                        round-robin, and rr_ptr ignores grants to requester 0.
// -----------------------------------------------------------------------------
module ram_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  ram_read_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so rr_ptr + offset can exceed NUM_REQ-1 before the wrap.
  localparam int IDX_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] NUM_REQ_I = IDX_W'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  // Round-robin pointer and the address held on the RAM port while idle.
  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;

  // Tag pipeline: a valid bit plus the one-hot grant per stage.
  logic               vld_q [RAM_LAT];
  logic               vld_d [RAM_LAT];
  logic [NUM_REQ-1:0] tag_q [RAM_LAT];
  logic [NUM_REQ-1:0] tag_d [RAM_LAT];

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  // Combinational arbitration results.
  logic [ADDR_W-1:0]  addr_arr_s [NUM_REQ];
  logic [NUM_REQ-1:0] grant_raw_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               gnt_any_raw_s;
  logic               gnt_any_s;
  logic [IDX_W-1:0]   idx_s;
  logic [ADDR_W-1:0]  ram_addr_s;
`ifdef ARB_BG_PRIORITY_EN
  logic [PTR_W-1:0]   base_s;
`endif

  // Unpack the flat request address bus into one entry per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr_s[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin search for the first valid requester at or after rr_ptr.
  always_comb begin
    grant_raw_s   = '0;
    gnt_idx_s     = '0;
    gnt_any_raw_s = 1'b0;
    idx_s         = '0;
`ifdef ARB_BG_PRIORITY_EN
    // rr_ptr lives in 1..NUM_REQ-1 for the shared group; a reset value of 0
    // simply means "start at requester 1".
    base_s = (rr_ptr_q == '0) ? PTR_W'(1) : rr_ptr_q;
    if (bus.req_valid[0]) begin
      grant_raw_s[0] = 1'b1;
      gnt_any_raw_s  = 1'b1;
      gnt_idx_s      = '0;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        idx_s = {1'b0, base_s} + IDX_W'(k);
        // Wrap past the last requester back to requester 1.
        if (idx_s >= NUM_REQ_I) begin
          idx_s = idx_s - IDX_W'(NUM_REQ - 1);
        end else begin
          idx_s = idx_s;
        end
        if (!gnt_any_raw_s && bus.req_valid[idx_s[PTR_W-1:0]]) begin
          grant_raw_s[idx_s[PTR_W-1:0]] = 1'b1;
          gnt_idx_s                     = idx_s[PTR_W-1:0];
          gnt_any_raw_s                 = 1'b1;
        end else begin
          gnt_any_raw_s = gnt_any_raw_s;
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, rr_ptr_q} + IDX_W'(k);
      // Explicit wrap so non-power-of-two NUM_REQ never leaves range.
      if (idx_s >= NUM_REQ_I) begin
        idx_s = idx_s - NUM_REQ_I;
      end else begin
        idx_s = idx_s;
      end
      if (!gnt_any_raw_s && bus.req_valid[idx_s[PTR_W-1:0]]) begin
        grant_raw_s[idx_s[PTR_W-1:0]] = 1'b1;
        gnt_idx_s                     = idx_s[PTR_W-1:0];
        gnt_any_raw_s                 = 1'b1;
      end else begin
        gnt_any_raw_s = gnt_any_raw_s;
      end
    end
`endif
  end

  // Suppress grants while Reset is held so nothing is accepted in reset.
  always_comb begin
    if (Reset) begin
      grant_s   = grant_raw_s;
      gnt_any_s = gnt_any_raw_s;
    end else begin
      grant_s   = '0;
      gnt_any_s = 1'b0;
    end
  end

  // RAM address mux and next pointer / held-address computation.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    last_addr_d = last_addr_q;
    ram_addr_s  = last_addr_q;
    if (gnt_any_s) begin
      ram_addr_s  = addr_arr_s[gnt_idx_s];
      last_addr_d = addr_arr_s[gnt_idx_s];
`ifdef ARB_BG_PRIORITY_EN
      if (gnt_idx_s == '0) begin
        rr_ptr_d = rr_ptr_q;
      end else if (gnt_idx_s == LAST_IDX) begin
        rr_ptr_d = PTR_W'(1);
      end else begin
        rr_ptr_d = gnt_idx_s + PTR_W'(1);
      end
`else
      if (gnt_idx_s == LAST_IDX) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + PTR_W'(1);
      end
`endif
    end else begin
      ram_addr_s = last_addr_q;
    end
  end

  // Tag pipeline next state: load the grant, shift, and expose the last stage.
  always_comb begin
    vld_d[0] = gnt_any_s;
    tag_d[0] = grant_s;
    for (int s = 1; s < RAM_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      tag_d[s] = tag_q[s-1];
    end
    if (vld_q[RAM_LAT-1]) begin
      rsp_valid_d = tag_q[RAM_LAT-1];
    end else begin
      rsp_valid_d = '0;
    end
  end

  // Arbiter state registers; reset drops every in-flight tag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rr_ptr_q    <= '0;
      last_addr_q <= '0;
      rsp_valid_q <= '0;
      for (int s = 0; s < RAM_LAT; s++) begin
        vld_q[s] <= 1'b0;
        tag_q[s] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      last_addr_q <= last_addr_d;
      rsp_valid_q <= rsp_valid_d;
      for (int s = 0; s < RAM_LAT; s++) begin
        vld_q[s] <= vld_d[s];
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.ram_addr  = ram_addr_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = bus.ram_data;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_read_arbiter
// Directed bench for ram_read_arbiter. Two instances share the same request
// stimulus: u_dut1 with RAM_LAT=1 and u_dut3 with RAM_LAT=3, each with its own
// RAM model whose read data appears in the cycle after edge N+RAM_LAT for an
// address presented at edge N. RAM contents: mem[0x12C00]=0xA5, otherwise
// mem[a] = a[7:0] ^ 0x5A.
// -----------------------------------------------------------------------------
module tb_ram_read_arbiter;

  logic Clk;
  logic Reset;

  int n_checks;
  int n_errors;

  ram_read_arbiter_if #(.NUM_REQ(3), .ADDR_W(19), .DATA_W(8)) bus1 ();
  ram_read_arbiter_if #(.NUM_REQ(3), .ADDR_W(19), .DATA_W(8)) bus3 ();

  ram_read_arbiter #(.NUM_REQ(3), .ADDR_W(19), .DATA_W(8), .RAM_LAT(1)) u_dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1.slave)
  );

  ram_read_arbiter #(.NUM_REQ(3), .ADDR_W(19), .DATA_W(8), .RAM_LAT(3)) u_dut3 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus3.slave)
  );

  assign bus3.req_valid = bus1.req_valid;
  assign bus3.req_addr  = bus1.req_addr;

  function automatic logic [7:0] mem_f(input logic [18:0] a);
    if (a == 19'h12C00) return 8'hA5;
    else return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] pipe1 [2];
  logic [7:0] pipe3 [4];

  always @(posedge Clk) begin
    pipe1[0] <= mem_f(bus1.ram_addr);
    pipe1[1] <= pipe1[0];
    pipe3[0] <= mem_f(bus3.ram_addr);
    for (int s = 1; s < 4; s++) pipe3[s] <= pipe3[s-1];
  end

  assign bus1.ram_data = pipe1[1];
  assign bus3.ram_data = pipe3[3];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  v;
    logic [18:0] a0;
    logic [18:0] a1;
    logic [18:0] a2;
    logic [2:0]  rdy;
    logic [18:0] ra;
    logic [2:0]  rsp1;
    logic [7:0]  d1;
    logic [2:0]  rsp3;
    logic [7:0]  d3;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] v, input logic [18:0] a0, input logic [18:0] a1,
                              input logic [18:0] a2, input logic [2:0] rdy, input logic [18:0] ra,
                              input logic [2:0] rsp1, input logic [7:0] d1,
                              input logic [2:0] rsp3, input logic [7:0] d3);
    vec_t r;
    r.v = v; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.rdy = rdy; r.ra = ra;
    r.rsp1 = rsp1; r.d1 = d1; r.rsp3 = rsp3; r.d3 = d3;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive requests just after a falling edge and let combinational outputs settle.
  task automatic drive(input logic [2:0] v, input logic [18:0] a0, input logic [18:0] a1,
                       input logic [18:0] a2);
    @(negedge Clk);
    bus1.req_valid = v;
    bus1.req_addr  = {a2, a1, a0};
    #1;
  endtask

  vec_t vt [24];

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b0;
    bus1.req_valid = 3'b000;
    bus1.req_addr  = '0;

    // Reset state.
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1;
    chk("reset ready", 32'(bus1.req_ready), 32'h0);
    chk("reset ram_addr", 32'(bus1.ram_addr), 32'h0);
    chk("reset rsp1", 32'(bus1.rsp_valid), 32'h0);
    chk("reset rsp3", 32'(bus3.rsp_valid), 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

`ifdef ARB_BG_PRIORITY_EN
    // Requester 0 dominates while valid; 1 and 2 then rotate among themselves.
    drive(3'b111, 19'h10, 19'h20, 19'h30);
    chk("bg p0 ready", 32'(bus1.req_ready), 32'h1);
    chk("bg p0 addr", 32'(bus1.ram_addr), 32'h10);
    drive(3'b111, 19'h10, 19'h20, 19'h30);
    chk("bg p1 ready", 32'(bus1.req_ready), 32'h1);
    drive(3'b111, 19'h10, 19'h20, 19'h30);
    chk("bg p2 ready", 32'(bus1.req_ready), 32'h1);
    chk("bg p2 rsp", 32'(bus1.rsp_valid), 32'h1);
    chk("bg p2 data", 32'(bus1.rsp_data), 32'h4A);
    drive(3'b110, 19'h10, 19'h20, 19'h30);
    chk("bg p3 ready", 32'(bus1.req_ready), 32'h2);
    chk("bg p3 addr", 32'(bus1.ram_addr), 32'h20);
    drive(3'b110, 19'h10, 19'h20, 19'h30);
    chk("bg p4 ready", 32'(bus1.req_ready), 32'h4);
    chk("bg p4 addr", 32'(bus1.ram_addr), 32'h30);
    drive(3'b111, 19'h10, 19'h20, 19'h30);
    chk("bg p5 ready", 32'(bus1.req_ready), 32'h1);
    drive(3'b110, 19'h10, 19'h20, 19'h30);
    chk("bg p6 ready", 32'(bus1.req_ready), 32'h2);
    chk("bg p6 rsp", 32'(bus1.rsp_valid), 32'h4);
    chk("bg p6 data", 32'(bus1.rsp_data), 32'h6A);
    drive(3'b000, 19'h10, 19'h20, 19'h30);
    chk("bg p7 ready", 32'(bus1.req_ready), 32'h0);
    chk("bg p7 addr", 32'(bus1.ram_addr), 32'h20);
`else
    //         v       a0         a1       a2       rdy     ram_addr   rsp1    d1     rsp3    d3
    vt[0]  = mk(3'b000, 19'h0,     19'h0,   19'h0,   3'b000, 19'h0,     3'b000, 8'h0,  3'b000, 8'h0);
    vt[1]  = mk(3'b001, 19'h12C00, 19'h0,   19'h0,   3'b001, 19'h12C00, 3'b000, 8'h0,  3'b000, 8'h0);
    vt[2]  = mk(3'b000, 19'h0,     19'h0,   19'h0,   3'b000, 19'h12C00, 3'b000, 8'h0,  3'b000, 8'h0);
    vt[3]  = mk(3'b111, 19'h10,    19'h20,  19'h30,  3'b010, 19'h20,    3'b001, 8'hA5, 3'b000, 8'h0);
    vt[4]  = mk(3'b111, 19'h10,    19'h20,  19'h30,  3'b100, 19'h30,    3'b000, 8'h0,  3'b000, 8'h0);
    vt[5]  = mk(3'b111, 19'h10,    19'h20,  19'h30,  3'b001, 19'h10,    3'b010, 8'h7A, 3'b001, 8'hA5);
    vt[6]  = mk(3'b111, 19'h10,    19'h20,  19'h30,  3'b010, 19'h20,    3'b100, 8'h6A, 3'b000, 8'h0);
    vt[7]  = mk(3'b100, 19'h10,    19'h20,  19'h30,  3'b100, 19'h30,    3'b001, 8'h4A, 3'b010, 8'h7A);
    vt[8]  = mk(3'b010, 19'h10,    19'h50,  19'h30,  3'b010, 19'h50,    3'b010, 8'h7A, 3'b100, 8'h6A);
    vt[9]  = mk(3'b000, 19'h10,    19'h50,  19'h30,  3'b000, 19'h50,    3'b100, 8'h6A, 3'b001, 8'h4A);
    vt[10] = mk(3'b000, 19'h10,    19'h50,  19'h30,  3'b000, 19'h50,    3'b010, 8'h0A, 3'b010, 8'h7A);
    vt[11] = mk(3'b000, 19'h10,    19'h50,  19'h30,  3'b000, 19'h50,    3'b000, 8'h0,  3'b100, 8'h6A);
    vt[12] = mk(3'b000, 19'h10,    19'h50,  19'h30,  3'b000, 19'h50,    3'b000, 8'h0,  3'b010, 8'h0A);
    vt[13] = mk(3'b101, 19'h60,    19'h50,  19'h40,  3'b100, 19'h40,    3'b000, 8'h0,  3'b000, 8'h0);
    vt[14] = mk(3'b010, 19'h60,    19'h50,  19'h40,  3'b010, 19'h50,    3'b000, 8'h0,  3'b000, 8'h0);
    vt[15] = mk(3'b000, 19'h60,    19'h50,  19'h40,  3'b000, 19'h50,    3'b100, 8'h1A, 3'b000, 8'h0);
    vt[16] = mk(3'b000, 19'h60,    19'h50,  19'h40,  3'b000, 19'h50,    3'b010, 8'h0A, 3'b000, 8'h0);
    vt[17] = mk(3'b000, 19'h60,    19'h50,  19'h40,  3'b000, 19'h50,    3'b000, 8'h0,  3'b100, 8'h1A);
    vt[18] = mk(3'b001, 19'h60,    19'h50,  19'h40,  3'b001, 19'h60,    3'b000, 8'h0,  3'b010, 8'h0A);
    vt[19] = mk(3'b001, 19'h10,    19'h50,  19'h40,  3'b001, 19'h10,    3'b000, 8'h0,  3'b000, 8'h0);
    vt[20] = mk(3'b000, 19'h10,    19'h50,  19'h40,  3'b000, 19'h10,    3'b001, 8'h3A, 3'b000, 8'h0);
    vt[21] = mk(3'b000, 19'h10,    19'h50,  19'h40,  3'b000, 19'h10,    3'b001, 8'h4A, 3'b000, 8'h0);
    vt[22] = mk(3'b000, 19'h10,    19'h50,  19'h40,  3'b000, 19'h10,    3'b000, 8'h0,  3'b001, 8'h3A);
    vt[23] = mk(3'b000, 19'h10,    19'h50,  19'h40,  3'b000, 19'h10,    3'b000, 8'h0,  3'b001, 8'h4A);

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].v, vt[i].a0, vt[i].a1, vt[i].a2);
      chk($sformatf("row%0d ready", i), 32'(bus1.req_ready), 32'(vt[i].rdy));
      chk($sformatf("row%0d ram_addr", i), 32'(bus1.ram_addr), 32'(vt[i].ra));
      chk($sformatf("row%0d ram_addr3", i), 32'(bus3.ram_addr), 32'(vt[i].ra));
      chk($sformatf("row%0d rsp1", i), 32'(bus1.rsp_valid), 32'(vt[i].rsp1));
      chk($sformatf("row%0d rsp3", i), 32'(bus3.rsp_valid), 32'(vt[i].rsp3));
      if (vt[i].rsp1 != 3'b000)
        chk($sformatf("row%0d data1", i), 32'(bus1.rsp_data), 32'(vt[i].d1));
      if (vt[i].rsp3 != 3'b000)
        chk($sformatf("row%0d data3", i), 32'(bus3.rsp_data), 32'(vt[i].d3));
    end
`endif

    // Reset mid-stream with a grant to requester 1 in flight.
    drive(3'b010, 19'h10, 19'h00100, 19'h30);
    chk("mid grant ready", 32'(bus1.req_ready), 32'h2);
    chk("mid grant addr", 32'(bus1.ram_addr), 32'h100);
    @(negedge Clk);
    bus1.req_valid = 3'b111;
    #1;
    Reset = 1'b0;
    #1;
    chk("in reset ready", 32'(bus1.req_ready), 32'h0);
    chk("in reset ram_addr", 32'(bus1.ram_addr), 32'h0);
    chk("in reset rsp1", 32'(bus1.rsp_valid), 32'h0);
    chk("in reset rsp3", 32'(bus3.rsp_valid), 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    bus1.req_valid = 3'b000;
    for (int i = 0; i < 5; i++) begin
      drive(3'b000, 19'h10, 19'h20, 19'h30);
      chk($sformatf("post reset%0d rsp1", i), 32'(bus1.rsp_valid), 32'h0);
      chk($sformatf("post reset%0d rsp3", i), 32'(bus3.rsp_valid), 32'h0);
      chk($sformatf("post reset%0d ram_addr", i), 32'(bus1.ram_addr), 32'h0);
    end
    drive(3'b111, 19'h10, 19'h20, 19'h30);
    chk("post reset ptr0 ready", 32'(bus1.req_ready), 32'h1);
    chk("post reset ptr0 addr", 32'(bus1.ram_addr), 32'h10);
    drive(3'b111, 19'h10, 19'h20, 19'h30);
`ifdef ARB_BG_PRIORITY_EN
    chk("post reset next ready", 32'(bus1.req_ready), 32'h1);
`else
    chk("post reset next ready", 32'(bus1.req_ready), 32'h2);
`endif
    drive(3'b000, 19'h10, 19'h20, 19'h30);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
